// File: rtl/cam_capture.sv
// cam_capture: RGB444 camera byte-stream capture into a frame buffer write port,
// with post-reset frame skipping, frame counting and sticky framing-error detection.
module cam_capture #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int FRAME_SKIP = 2
) (
    input  logic        i_p_clk,
    input  logic        i_rstn,
    input  logic        i_cam_vsync,
    input  logic        i_cam_href,
    input  logic [7:0]  i_cam_data,
    input  logic        i_err_clr,
    output logic        o_we,
    output logic [18:0] o_waddr,
    output logic [11:0] o_wdata,
    output logic        o_frame_active,
    output logic        o_frame_done,
    output logic [7:0]  o_frame_cnt,
    output logic        o_err
);
    localparam logic [19:0] TOTAL      = 20'(H_PIXELS * V_LINES);
    localparam logic [15:0] LINE_BYTES = 16'(2 * H_PIXELS);
    localparam logic [15:0] LINES      = 16'(V_LINES);
    localparam logic [7:0]  SKIP_LAST  = 8'(FRAME_SKIP - 1);

    typedef enum logic [1:0] {SKIP, ARMED, CAPTURE} state_t;

    state_t      state;
    logic        vs_r, vs_q, hr_r, hr_q, phase;
    logic [7:0]  d_r, skip_cnt;
    logic [3:0]  red;
    logic [15:0] byte_cnt, line_cnt;
    logic [19:0] pix_cnt;
    logic        vs_rise, vs_fall, hr_fall, err_set;

    always_comb begin
        vs_rise = vs_r && !vs_q;
        vs_fall = !vs_r && vs_q;
        hr_fall = !hr_r && hr_q;
        // a vsync rise with href still high is a truncated line
        err_set = (state == CAPTURE) &&
                  (vs_rise ? (pix_cnt != TOTAL || line_cnt != LINES || hr_r) :
                   hr_r    ? (phase && pix_cnt >= TOTAL) :
                             (hr_fall && byte_cnt != LINE_BYTES));
    end

    always_ff @(posedge i_p_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= SKIP;
            {vs_r, vs_q, hr_r, hr_q, phase} <= '0;
            d_r            <= '0;
            skip_cnt       <= '0;
            red            <= '0;
            byte_cnt       <= '0;
            line_cnt       <= '0;
            pix_cnt        <= '0;
            o_we           <= 1'b0;
            o_waddr        <= '0;
            o_wdata        <= '0;
            o_frame_active <= 1'b0;
            o_frame_done   <= 1'b0;
            o_frame_cnt    <= '0;
            o_err          <= 1'b0;
        end else begin
            {vs_q, vs_r} <= {vs_r, i_cam_vsync};
            {hr_q, hr_r} <= {hr_r, i_cam_href};
            d_r          <= i_cam_data;
            o_we         <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= err_set || (o_err && !i_err_clr);
            case (state)
                SKIP: begin
                    if (FRAME_SKIP == 0) state <= ARMED;
                    else if (vs_rise) begin
                        if (skip_cnt == SKIP_LAST) state <= ARMED;
                        skip_cnt <= skip_cnt + 8'd1;
                    end
                end
                ARMED: begin
                    if (vs_fall) begin
                        state          <= CAPTURE;
                        o_frame_active <= 1'b1;
                        pix_cnt        <= '0;
                        phase          <= 1'b0;
                        byte_cnt       <= '0;
                        line_cnt       <= '0;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        state          <= ARMED;
                        o_frame_active <= 1'b0;
                        o_frame_done   <= 1'b1;
                        o_frame_cnt    <= o_frame_cnt + 8'd1;
                    end else if (hr_r) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        phase    <= !phase;
                        if (!phase) red <= d_r[3:0];
                        else if (pix_cnt < TOTAL) begin
                            o_we    <= 1'b1;
                            o_waddr <= pix_cnt[18:0];
                            o_wdata <= {red, d_r};
                            pix_cnt <= pix_cnt + 20'd1;
                        end
                    end else if (hr_fall) begin
                        line_cnt <= line_cnt + 16'd1;
                        phase    <= 1'b0;
                        byte_cnt <= '0;
                    end
                end
                default: state <= SKIP;
            endcase
        end
    end
endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001: Parameter H_PIXELS, default 640, pixels per line.
REQ-002: Parameter V_LINES, default 480, lines per frame.
REQ-003: Parameter FRAME_SKIP, default 2, full camera frames discarded after reset (camera configuration settle time).
REQ-004: i_p_clk  input  1  camera pixel clock; all logic on rising edge.
REQ-005: i_rstn  input  1  asynchronous active-low reset.
REQ-006: i_cam_vsync  input  1  camera VSYNC, high between frames.
REQ-007: i_cam_href  input  1  camera HREF, high while line bytes valid.
REQ-008: i_cam_data  input  8  camera byte bus (RGB444: byte0 = xxxxRRRR, byte1 = GGGGBBBB).
REQ-009: i_err_clr  input  1  synchronous clear of o_err.
REQ-010: o_we  output  1  frame buffer write strobe, one cycle per pixel.
REQ-011: o_waddr  output  19  frame buffer write address.
REQ-012: o_wdata  output  12  pixel {R,G,B} 4 bits each.
REQ-013: o_frame_active  output  1  high while in CAPTURE.
REQ-014: o_frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-015: o_frame_cnt  output  8  completed captured frames, wraps 255->0.
REQ-016: o_err  output  1  sticky framing error flag.

Function
REQ-017: Inputs shall be registered once; edge detection (vsync rise/fall, href fall) shall use the registered value versus its previous registered value.
REQ-018: States: SKIP, ARMED, CAPTURE.
REQ-019: SKIP: count vsync rising edges; on the FRAME_SKIP-th rise go to ARMED; FRAME_SKIP=0 shall go to ARMED on the first cycle after reset.
REQ-020: ARMED: on vsync falling edge go to CAPTURE; clear address, byte phase, line byte count, line count.
REQ-021: CAPTURE, href=1, phase 0: latch data[3:0] as R; phase shall toggle to 1.
REQ-022: CAPTURE, href=1, phase 1: register o_wdata={R,data[7:0]}, o_waddr=pixel address, o_we=1; pixel address shall increment; phase returns to 0.
REQ-023: o_we shall be high exactly one cycle per pixel, visible the cycle after the phase-1 byte is registered; o_waddr/o_wdata shall hold their last value while o_we=0.
REQ-024: Line byte counter shall increment per href-high byte; on href falling edge: if count != 2*H_PIXELS set o_err; line count increments; phase and byte count shall clear.
REQ-025: Pixel address shall never exceed H_PIXELS*V_LINES-1 (307199 default); a pixel beyond it shall not be written (o_we stays 0) and shall set o_err.
REQ-026: Vsync rising edge in CAPTURE: pulse o_frame_done one cycle, increment o_frame_cnt, set o_err if pixels written != H_PIXELS*V_LINES or line count != V_LINES, go to ARMED.
REQ-027: Vsync rise coinciding with href=1 shall end the frame; the partial line shall not increment line count and shall set o_err.
REQ-028: o_err shall clear on i_err_clr=1 unless a set condition occurs the same cycle (set wins).
REQ-029: href activity in SKIP or ARMED shall be ignored (no writes, no error).

Reset
REQ-030: i_rstn low shall immediately force: state SKIP, skip count 0, o_we 0, o_waddr 0, o_wdata 0, o_frame_active 0, o_frame_done 0, o_frame_cnt 0, o_err 0, phase 0, all counters 0.
REQ-031: Reset asserted mid-frame shall abort the frame with no further writes; after release the full FRAME_SKIP sequence shall repeat.

Verification
REQ-032: Reset, then 2 vsync pulses with href toggling -> no o_we; state ARMED after second vsync rise.
REQ-033: One full 640x480 frame of bytes 0x0A,0xBC per pixel -> 307200 o_we pulses, o_wdata=0xABC, o_waddr 0..307199, one o_frame_done, o_frame_cnt=1, o_err=0.
REQ-034: Line with 1278 bytes (odd pixel short) -> o_err=1 after href fall; asserting i_err_clr for one cycle -> o_err=0.
REQ-035: Frame with 481 lines -> writes stop at address 307199, o_err=1, o_frame_done still pulses.
REQ-036: i_rstn low at pixel 1000 of frame -> o_we 0 immediately, o_frame_cnt=0; after release no writes until 2 skipped frames plus a vsync fall.
REQ-037: 256 good frames -> o_frame_cnt wraps to 0, o_err=0.
